data_mem_access_unit: RTL and testbench

// - KGP-RISC load/store front end. Takes the effective address (alu_out) and store data from
//   EX, runs a req/ack transaction with data memory, and returns the registered load word on

---
 rtl/kgp_pkg.sv | 25 ++
 rtl/dmau_wait_timer.sv | 32 +++
 rtl/data_mem_access_unit.sv | 131 +++++++++++++
 tb/tb_data_mem_access_unit.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kgp_pkg.sv
// Shared KGP-RISC definitions: data-memory FSM state encoding, word geometry and the
// MemToReg select codes used by the write-back mux.
package kgp_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int WORD_BYTES = 4;

    localparam logic [1:0] MEM_TO_REG_ALU = 2'b00;
    localparam logic [1:0] MEM_TO_REG_PC4 = 2'b01;
    localparam logic [1:0] MEM_TO_REG_MEM = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_REQ  = S_REQ,
        ST_DONE = S_DONE
    } dmau_state_t;

    function automatic logic is_word_aligned(input logic [1:0] byte_offset);
        return byte_offset == 2'b00;
    endfunction

endpackage

// File: rtl/dmau_wait_timer.sv
// Saturating wait-cycle counter for the data-memory handshake; expired flags the last
// REQ cycle allowed before the transaction is abandoned.
module dmau_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && count_reg != LIMIT) begin
            count_reg <= count_reg + CW'(1);
        end
    end

    // The count reaches TIMEOUT at the end of this cycle, so this is the final REQ cycle.
    assign expired = enable && (count_reg >= LAST);

endmodule

// File: rtl/data_mem_access_unit.sv
// KGP-RISC load/store front end: captures an aligned EX-stage access, runs the req/ack
// handshake with data memory, stalls the core meanwhile and returns the registered load word.
module data_mem_access_unit
    import kgp_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MEM_ADDR_W = 10,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [31:0]           addr,
    input  logic [DATA_W-1:0]     store_data,
    output logic                  stall,
    output logic [DATA_W-1:0]     load_data,
    output logic                  load_valid,
    output logic                  misaligned,
    output logic                  bus_err,
    output logic                  dm_req,
    output logic                  dm_we,
    output logic [MEM_ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0]     dm_wdata,
    input  logic                  dm_ack,
    input  logic [DATA_W-1:0]     dm_rdata
);

    dmau_state_t state_reg, state_next;

    logic [MEM_ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0]     wdata_reg;
    logic [DATA_W-1:0]     load_data_reg;
    logic                  we_reg;
    logic                  read_ok_reg;
    logic                  timeout_reg;

    logic one_req, both_req, aligned, accept, conflict_err;
    logic req_active, timer_expired;
    logic unused_addr_bits;

    assign one_req    = mem_read ^ mem_write;
    assign both_req   = mem_read & mem_write;
    assign aligned    = is_word_aligned(addr[1:0]);
    assign req_active = (state_reg == ST_REQ);

    assign unused_addr_bits = ^addr[31:MEM_ADDR_W+2];

    dmau_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept),
        .enable  (req_active),
        .expired (timer_expired)
    );

    // IDLE and DONE share the request-decode path, which gives back-to-back accesses.
    always_comb begin
        state_next   = state_reg;
        stall        = 1'b0;
        misaligned   = 1'b0;
        accept       = 1'b0;
        conflict_err = 1'b0;
        case (state_reg)
            ST_REQ: begin
                stall = 1'b1;
                if (dm_ack || timer_expired) begin
                    state_next = ST_DONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                if (one_req && aligned) begin
                    accept     = 1'b1;
                    stall      = 1'b1;
                    state_next = ST_REQ;
                end else if (one_req) begin
                    misaligned = 1'b1;
                end else if (both_req) begin
                    conflict_err = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            we_reg        <= 1'b0;
            load_data_reg <= '0;
            read_ok_reg   <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                addr_reg  <= addr[MEM_ADDR_W+1:2];
                wdata_reg <= store_data;
                we_reg    <= mem_write;
            end
            if (req_active) begin
                if (dm_ack) begin
                    if (!we_reg) begin
                        load_data_reg <= dm_rdata;
                    end
                    read_ok_reg <= !we_reg;
                    timeout_reg <= 1'b0;
                end else if (timer_expired) begin
                    // An abandoned load leaves a defined zero rather than stale data.
                    if (!we_reg) begin
                        load_data_reg <= '0;
                    end
                    read_ok_reg <= 1'b0;
                    timeout_reg <= 1'b1;
                end
            end
        end
    end

    assign dm_req     = req_active;
    assign dm_we      = we_reg;
    assign dm_addr    = addr_reg;
    assign dm_wdata   = wdata_reg;
    assign load_data  = load_data_reg;
    assign load_valid = (state_reg == ST_DONE) && read_ok_reg;
    assign bus_err    = conflict_err || ((state_reg == ST_DONE) && timeout_reg);

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Scoreboard bench for data_mem_access_unit: a memory model answers dm_req after a
// programmable delay, a monitor compares each bus cycle and load result against queued expectations.
module tb_data_mem_access_unit;

    localparam int DATA_W     = 32;
    localparam int MEM_ADDR_W = 10;
    localparam int TIMEOUT    = 15;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  mem_read = 1'b0;
    logic                  mem_write = 1'b0;
    logic [31:0]           addr = '0;
    logic [DATA_W-1:0]     store_data = '0;
    logic                  stall;
    logic [DATA_W-1:0]     load_data;
    logic                  load_valid;
    logic                  misaligned;
    logic                  bus_err;
    logic                  dm_req;
    logic                  dm_we;
    logic [MEM_ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0]     dm_wdata;
    logic                  dm_ack = 1'b0;
    logic [DATA_W-1:0]     dm_rdata = '0;

    typedef struct {
        logic                  we;
        logic [MEM_ADDR_W-1:0] waddr;
        logic [DATA_W-1:0]     data;
    } acc_t;

    acc_t        exp_acc[$];
    logic [31:0] pend_load[$];
    logic [31:0] mem_model [0:1023];

    int n_checks    = 0;
    int n_fail      = 0;
    int ack_delay   = 0;
    int req_cycles  = 0;
    int bus_err_cnt = 0;

    data_mem_access_unit #(
        .DATA_W     (DATA_W),
        .MEM_ADDR_W (MEM_ADDR_W),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .addr       (addr),
        .store_data (store_data),
        .stall      (stall),
        .load_data  (load_data),
        .load_valid (load_valid),
        .misaligned (misaligned),
        .bus_err    (bus_err),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_ack     (dm_ack),
        .dm_rdata   (dm_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tick();
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    // Memory model: acks after ack_delay wait cycles of dm_req.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (dm_req) begin
                if (wait_cnt == ack_delay) begin
                    dm_ack   = 1'b1;
                    dm_rdata = mem_model[dm_addr];
                end else begin
                    dm_ack = 1'b0;
                end
                wait_cnt++;
            end else begin
                dm_ack   = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // Monitor: bus-cycle and load-result scoreboard.
    initial begin
        acc_t        e;
        logic        prev_req;
        logic [31:0] exp_ld;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (dm_req) begin
                    req_cycles++;
                    if (exp_acc.size() == 0) begin
                        check_eq("unexpected_dm_req", 32'(dm_req), 32'd0);
                    end else begin
                        e = exp_acc[0];
                        check_eq("dm_we", 32'(dm_we), 32'(e.we));
                        check_eq("dm_addr", 32'(dm_addr), 32'(e.waddr));
                        if (e.we) check_eq("dm_wdata", dm_wdata, e.data);
                        if (dm_ack) begin
                            if (e.we) mem_model[dm_addr] = dm_wdata;
                            else pend_load.push_back(e.data);
                            e = exp_acc.pop_front();
                        end
                    end
                end
                if (load_valid) begin
                    if (pend_load.size() == 0) begin
                        check_eq("unexpected_load_valid", 32'(load_valid), 32'd0);
                    end else begin
                        exp_ld = pend_load.pop_front();
                        check_eq("load_data", load_data, exp_ld);
                    end
                end
                if (bus_err) begin
                    bus_err_cnt++;
                    if (prev_req && exp_acc.size() > 0) e = exp_acc.pop_front();
                end
                prev_req = dm_req;
            end else begin
                prev_req = 1'b0;
            end
        end
    end

    // Presents one access, drops it once DONE is reached, returns the stall-cycle count.
    task automatic run_op(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, output int stalls);
        logic was_req;
        logic done;
        mem_read   = rd;
        mem_write  = wr;
        addr       = a;
        store_data = d;
        stalls     = 0;
        was_req    = 1'b0;
        done       = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (was_req && !dm_req) begin
                mem_read  = 1'b0;
                mem_write = 1'b0;
            end
            @(negedge clk);
            if (!stall) begin
                done = 1'b1;
                break;
            end
            stalls++;
            was_req = dm_req;
            tick();
        end
        if (!done) begin
            check_eq("op_completion", 32'(done), 32'd1);
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
        $display("op rd=%0d wr=%0d addr=0x%08h stall_cycles=%0d load_data=0x%08h bus_err=%0d",
                 rd, wr, a, stalls, load_data, bus_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int rc0;
        for (int i = 0; i < 1024; i++) mem_model[i] = $urandom;
        mem_model[4]  = 32'hCAFE_F00D;
        mem_model[12] = 32'hA5A5_0001;
        mem_model[24] = 32'h600D_1DEA;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_dm_req", 32'(dm_req), 32'd0);
        check_eq("rst_dm_we", 32'(dm_we), 32'd0);
        check_eq("rst_dm_addr", 32'(dm_addr), 32'd0);
        check_eq("rst_dm_wdata", dm_wdata, 32'd0);
        check_eq("rst_load_data", load_data, 32'd0);
        check_eq("rst_load_valid", 32'(load_valid), 32'd0);
        check_eq("rst_misaligned", 32'(misaligned), 32'd0);
        check_eq("rst_bus_err", 32'(bus_err), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Load, ack in first REQ cycle
        ack_delay = 0;
        exp_acc.push_back('{we: 1'b0, waddr: 10'd4, data: 32'hCAFE_F00D});
        run_op(1'b1, 1'b0, 32'h0000_0010, 32'h0, s);
        check_eq("load_stall_cycles", 32'(s), 32'd2);
        check_eq("load_result", load_data, 32'hCAFE_F00D);
        idle();

        // Store with 3 wait cycles
        ack_delay = 3;
        rc0 = req_cycles;
        exp_acc.push_back('{we: 1'b1, waddr: 10'd8, data: 32'h1234_5678});
        run_op(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, s);
        check_eq("store_stall_cycles", 32'(s), 32'd5);
        check_eq("store_req_cycles", 32'(req_cycles - rc0), 32'd4);
        check_eq("store_keeps_load_data", load_data, 32'hCAFE_F00D);
        check_eq("store_mem_written", mem_model[8], 32'h1234_5678);
        idle();

        // Misaligned load
        rc0 = req_cycles;
        mem_read = 1'b1;
        addr     = 32'h0000_0013;
        @(negedge clk);
        check_eq("misaligned_pulse", 32'(misaligned), 32'd1);
        check_eq("misaligned_stall", 32'(stall), 32'd0);
        $display("op rd=1 wr=0 addr=0x%08h misaligned=%0d", addr, misaligned);
        idle();
        @(negedge clk);
        check_eq("misaligned_cleared", 32'(misaligned), 32'd0);
        check_eq("misaligned_no_req", 32'(req_cycles - rc0), 32'd0);
        check_eq("misaligned_dm_req", 32'(dm_req), 32'd0);
        tick();

        // Read and write both set
        mem_read  = 1'b1;
        mem_write = 1'b1;
        addr      = 32'h0000_0010;
        @(negedge clk);
        check_eq("conflict_bus_err", 32'(bus_err), 32'd1);
        check_eq("conflict_stall", 32'(stall), 32'd0);
        $display("op rd=1 wr=1 addr=0x%08h bus_err=%0d", addr, bus_err);
        idle();
        @(negedge clk);
        check_eq("conflict_no_req", 32'(dm_req), 32'd0);
        tick();

        // Timeout on a load
        ack_delay = 99;
        exp_acc.push_back('{we: 1'b0, waddr: 10'd28, data: 32'h0});
        run_op(1'b1, 1'b0, 32'h0000_0070, 32'h0, s);
        check_eq("timeout_stall_cycles", 32'(s), 32'(TIMEOUT + 1));
        check_eq("timeout_bus_err", 32'(bus_err), 32'd1);
        check_eq("timeout_load_data", load_data, 32'd0);
        check_eq("timeout_load_valid", 32'(load_valid), 32'd0);
        idle();
        @(negedge clk);
        check_eq("timeout_idle_req", 32'(dm_req), 32'd0);
        check_eq("timeout_idle_bus_err", 32'(bus_err), 32'd0);
        tick();

        // Back-to-back load then store, next request presented in DONE
        ack_delay = 0;
        exp_acc.push_back('{we: 1'b0, waddr: 10'd12, data: 32'hA5A5_0001});
        exp_acc.push_back('{we: 1'b1, waddr: 10'd16, data: 32'h0BAD_BEEF});
        mem_read = 1'b1;
        addr     = 32'h0000_0030;
        @(negedge clk);
        check_eq("b2b_accept_stall", 32'(stall), 32'd1);
        tick();
        @(negedge clk);
        check_eq("b2b_load_req", 32'(dm_req), 32'd1);
        tick();
        mem_read   = 1'b0;
        mem_write  = 1'b1;
        addr       = 32'h0000_0040;
        store_data = 32'h0BAD_BEEF;
        @(negedge clk);
        check_eq("b2b_done_load_valid", 32'(load_valid), 32'd1);
        check_eq("b2b_done_stall", 32'(stall), 32'd1);
        tick();
        @(negedge clk);
        check_eq("b2b_store_req", 32'(dm_req), 32'd1);
        check_eq("b2b_store_we", 32'(dm_we), 32'd1);
        tick();
        mem_write = 1'b0;
        @(negedge clk);
        check_eq("b2b_store_done_stall", 32'(stall), 32'd0);
        check_eq("b2b_store_mem", mem_model[16], 32'h0BAD_BEEF);
        check_eq("b2b_load_data_kept", load_data, 32'hA5A5_0001);
        $display("op b2b load=0x%08h store mem[16]=0x%08h", load_data, mem_model[16]);
        tick();

        // Reset in the 2nd REQ cycle
        ack_delay = 10;
        exp_acc.push_back('{we: 1'b0, waddr: 10'd20, data: 32'h0});
        mem_read = 1'b1;
        addr     = 32'h0000_0050;
        tick();
        tick();
        #2;
        rst_n    = 1'b0;
        mem_read = 1'b0;
        #1;
        check_eq("rst_mid_dm_req", 32'(dm_req), 32'd0);
        check_eq("rst_mid_stall", 32'(stall), 32'd0);
        check_eq("rst_mid_load_data", load_data, 32'd0);
        $display("op reset mid-REQ dm_req=%0d stall=%0d", dm_req, stall);
        exp_acc.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Clean load after reset
        ack_delay = 1;
        exp_acc.push_back('{we: 1'b0, waddr: 10'd24, data: 32'h600D_1DEA});
        run_op(1'b1, 1'b0, 32'h0000_0060, 32'h0, s);
        check_eq("post_rst_stall_cycles", 32'(s), 32'd3);
        check_eq("post_rst_load", load_data, 32'h600D_1DEA);
        idle();
        @(negedge clk);

        check_eq("scoreboard_acc_empty", 32'(exp_acc.size()), 32'd0);
        check_eq("scoreboard_load_empty", 32'(pend_load.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
